// File: rtl/piso_serializer_if.sv
// Load and serial-side handshake bundle for the PISO serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_ready;
  logic             serial_valid;
  logic             serial_out;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  modport master (
    output load_valid, parallel_in, serial_ready,
    input  load_ready, serial_valid, serial_out, frame_start, frame_last, busy
  );

  modport slave (
    input  load_valid, parallel_in, serial_ready,
    output load_ready, serial_valid, serial_out, frame_start, frame_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready on both sides and
// first/last-bit frame markers; supports zero-gap back-to-back words.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             reset,
  piso_serializer_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam int unsigned OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic in_shift;
  logic on_last;
  logic xfer;
  logic load_ready;
  logic load_acc;

  assign in_shift   = (state_q == SHIFT);
  assign on_last    = (bit_cnt_q == LAST_CNT);
  assign xfer       = in_shift && bus.serial_ready;
  // serial_ready feeds load_ready combinationally so a new word can follow the last bit
  assign load_ready = !reset && (!in_shift || (on_last && bus.serial_ready));
  assign load_acc   = bus.load_valid && load_ready;

  assign bus.load_ready   = load_ready;
  assign bus.serial_valid = in_shift;
  assign bus.busy         = in_shift;
  assign bus.serial_out   = in_shift && shreg_q[OUT_IDX];
  assign bus.frame_start  = in_shift && (bit_cnt_q == '0);
  assign bus.frame_last   = in_shift && on_last;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (load_acc) begin
          state_d   = SHIFT;
          shreg_d   = bus.parallel_in;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (on_last) begin
            if (load_acc) begin
              shreg_d   = bus.parallel_in;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a 4-bit LSB-first and an 8-bit
// MSB-first instance, directed sequences plus randomized traffic.
module tb_piso_serializer;
  typedef logic [2:0] ent_t;  // {bit, frame_start, frame_last}

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) ia ();
  piso_serializer_if #(.WIDTH(8)) ib ();

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(rst_b), .bus(ib));

  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   rnd_en = 1'b0;
  bit   prev_rst_a = 1'b1, prev_rst_b = 1'b1;
  ent_t q_a[$];
  ent_t q_b[$];
  bit   log_a[$];
  bit   log_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsz(input int id);
    return (id == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic ent_t qfront(input int id);
    return (id == 0) ? q_a[0] : q_b[0];
  endfunction

  function automatic void qpop(input int id, input bit b);
    if (id == 0) begin void'(q_a.pop_front()); log_a.push_back(b); end
    else begin void'(q_b.pop_front()); log_b.push_back(b); end
  endfunction

  // Reference: a word becomes W entries in transmit order with first/last markers
  function automatic void push_word(input int id, input logic [7:0] w);
    int  wd  = (id == 0) ? 4 : 8;
    bit  lsb = (id == 0);
    for (int i = 0; i < wd; i++) begin
      ent_t e;
      e = {(lsb ? w[i] : w[wd-1-i]), (i == 0), (i == wd - 1)};
      if (id == 0) q_a.push_back(e); else q_b.push_back(e);
    end
  endfunction

  task automatic monitor(input int id, input logic rst, input logic prev_rst,
                         input logic lv, input logic lr, input logic [7:0] pin,
                         input logic sr, input logic sv, input logic so,
                         input logic fs, input logic fl, input logic bz);
    int sz = qsz(id);
    if (rst) begin
      chk($sformatf("lr_in_reset[%0d]", id), lr, 1'b0);
      if (prev_rst) chk($sformatf("valid_in_reset[%0d]", id), sv, 1'b0);
      if (id == 0) q_a.delete(); else q_b.delete();
      return;
    end
    chk($sformatf("load_ready[%0d]", id), lr, (sz == 0) || (sz == 1 && sr));
    chk($sformatf("serial_valid[%0d]", id), sv, sz != 0);
    chk($sformatf("busy[%0d]", id), bz, sz != 0);
    if (sz != 0) begin
      chk($sformatf("bit_flags[%0d]", id), {so, fs, fl}, qfront(id));
      if (sr) qpop(id, so);
    end else begin
      chk($sformatf("idle_outputs[%0d]", id), {so, fs, fl}, 3'b000);
    end
    if (lv && lr) push_word(id, pin);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor(0, rst_a, prev_rst_a, ia.load_valid, ia.load_ready, 8'(ia.parallel_in),
              ia.serial_ready, ia.serial_valid, ia.serial_out, ia.frame_start,
              ia.frame_last, ia.busy);
      monitor(1, rst_b, prev_rst_b, ib.load_valid, ib.load_ready, ib.parallel_in,
              ib.serial_ready, ib.serial_valid, ib.serial_out, ib.frame_start,
              ib.frame_last, ib.busy);
      prev_rst_a = rst_a;
      prev_rst_b = rst_b;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) begin
      ia.serial_ready = 1'($urandom_range(0, 1));
      ib.serial_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input int id, input logic [7:0] w);
    bit done = 1'b0;
    if (id == 0) begin ia.load_valid = 1'b1; ia.parallel_in = w[3:0]; end
    else begin ib.load_valid = 1'b1; ib.parallel_in = w; end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if ((id == 0) ? ia.load_ready : ib.load_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (id == 0) ia.load_valid = 1'b0; else ib.load_valid = 1'b0;
    chk($sformatf("load_accept[%0d]", id), done, 1'b1);
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int c = 0; c < 500 && !empty; c++) begin
      tick();
      empty = (q_a.size() == 0) && (q_b.size() == 0) && !ia.busy && !ib.busy;
    end
    chk("drain", empty, 1'b1);
  endtask

  task automatic check_seq(input int id, input string name, input logic [7:0] exp, input int len);
    logic [7:0] v = '0;
    int n = (id == 0) ? log_a.size() : log_b.size();
    for (int i = 0; i < n; i++) v = {v[6:0], ((id == 0) ? log_a[i] : log_b[i])};
    chk({name, "_len"}, n, len);
    chk({name, "_bits"}, v, exp);
    log_a.delete();
    log_b.delete();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ia.load_valid = 1'b1; ia.parallel_in = 4'b1111; ia.serial_ready = 1'b1;
    ib.load_valid = 1'b0; ib.parallel_in = 8'h00;   ib.serial_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst_a = 1'b0; rst_b = 1'b0; ia.load_valid = 1'b0;
    tick();
    chk("no_frame_after_reset", log_a.size(), 0);

    load_word(0, 8'h0B);
    drain();
    check_seq(0, "single_lsb", 8'b0000_1101, 4);

    load_word(0, 8'h09);
    load_word(0, 8'h06);
    drain();
    check_seq(0, "back_to_back", 8'b1001_0110, 8);

    load_word(0, 8'h05);
    tick();
    ia.serial_ready = 1'b0;
    tick(); tick();
    ia.serial_ready = 1'b1;
    drain();
    check_seq(0, "stall", 8'b0000_1010, 4);

    load_word(0, 8'h03);
    tick();
    ia.load_valid = 1'b1; ia.parallel_in = 4'b1111;
    tick();
    ia.load_valid = 1'b0;
    drain();
    check_seq(0, "ignored_load", 8'b0000_1100, 4);

    load_word(0, 8'h03);
    tick(); tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
    chk("valid_after_midreset", ia.serial_valid, 1'b0);
    log_a.delete();
    load_word(0, 8'h0C);
    drain();
    check_seq(0, "after_midreset", 8'b0000_0011, 4);

    load_word(1, 8'hA5);
    drain();
    check_seq(1, "msb_first", 8'b1010_0101, 8);

    rnd_en = 1'b1;
    fork
      for (int i = 0; i < 40; i++) begin
        load_word(0, 8'($urandom_range(0, 15)));
        repeat ($urandom_range(0, 2)) tick();
      end
      for (int i = 0; i < 30; i++) begin
        load_word(1, 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) tick();
      end
    join
    rnd_en = 1'b0;
    tick();
    ia.serial_ready = 1'b1; ib.serial_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
